// File: rtl/dm_cache_wb.sv
// Direct-mapped write-back, write-allocate cache controller with a dirty bit per
// line, CPU valid/ready request port, multi-cycle memory handshake and full flush.
module dm_cache_wb #(
    parameter int ADDR_BITS  = 5,
    parameter int INDEX_BITS = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    input  logic                  flush,
    output logic                  flush_done
);
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_WRITEBACK, S_REFILL, S_FLUSH_CHECK, S_FLUSH_WB
    } state_t;

    state_t                state, state_n;
    logic [LINES-1:0]      valid, dirty;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES];

    logic                  lat_we;
    logic [ADDR_BITS-1:0]  lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [INDEX_BITS:0]   cnt, cnt_n;

    logic                  resp_valid_n, mem_req_n, mem_we_n, flush_done_n;
    logic [DATA_WIDTH-1:0] resp_rdata_n, mem_wdata_n, data_wval;
    logic [ADDR_BITS-1:0]  mem_addr_n;
    logic                  accept, line_we, line_valid_n, line_dirty_n, data_we, tag_we;
    logic [INDEX_BITS-1:0] line_idx;

    logic [INDEX_BITS-1:0] cur_idx, fidx;
    logic [TAG_BITS-1:0]   cur_tag;
    logic                  hit, acked;

    assign cur_idx   = lat_addr[INDEX_BITS-1:0];
    assign cur_tag   = lat_addr[ADDR_BITS-1:INDEX_BITS];
    assign fidx      = cnt[INDEX_BITS-1:0];
    assign hit       = valid[cur_idx] && (tag_mem[cur_idx] == cur_tag);
    assign acked     = mem_req && mem_ack;
    assign req_ready = (state == S_IDLE) && !flush;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        resp_valid_n = 1'b0;
        resp_rdata_n = resp_rdata;
        mem_req_n    = mem_req;
        mem_we_n     = mem_we;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        flush_done_n = 1'b0;
        accept       = 1'b0;
        line_we      = 1'b0;
        line_idx     = cur_idx;
        line_valid_n = 1'b0;
        line_dirty_n = 1'b0;
        data_we      = 1'b0;
        data_wval    = lat_wdata;
        tag_we       = 1'b0;
        case (state)
            S_IDLE: begin
                if (flush) begin
                    state_n = S_FLUSH_CHECK;
                    cnt_n   = '0;
                end else if (req_valid) begin
                    accept  = 1'b1;
                    state_n = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    resp_valid_n = 1'b1;
                    state_n      = S_IDLE;
                    if (lat_we) begin
                        data_we      = 1'b1;
                        line_we      = 1'b1;
                        line_valid_n = 1'b1;
                        line_dirty_n = 1'b1;
                    end else begin
                        resp_rdata_n = data_mem[cur_idx];
                    end
                end else if (valid[cur_idx] && dirty[cur_idx]) begin
                    state_n     = S_WRITEBACK;
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b1;
                    mem_addr_n  = {tag_mem[cur_idx], cur_idx};
                    mem_wdata_n = data_mem[cur_idx];
                end else begin
                    state_n    = S_REFILL;
                    mem_req_n  = 1'b1;
                    mem_we_n   = 1'b0;
                    mem_addr_n = lat_addr;
                end
            end
            S_WRITEBACK: begin
                if (acked) begin
                    mem_req_n = 1'b0;
                    mem_we_n  = 1'b0;
                    state_n   = S_REFILL;
                end
            end
            S_REFILL: begin
                // Entered from WRITEBACK with mem_req low; re-issue as a read here
                if (acked) begin
                    mem_req_n    = 1'b0;
                    data_we      = 1'b1;
                    data_wval    = mem_rdata;
                    tag_we       = 1'b1;
                    line_we      = 1'b1;
                    line_valid_n = 1'b1;
                    state_n      = S_COMPARE;
                end else begin
                    mem_req_n  = 1'b1;
                    mem_we_n   = 1'b0;
                    mem_addr_n = lat_addr;
                end
            end
            S_FLUSH_CHECK: begin
                line_idx = fidx;
                if (cnt[INDEX_BITS]) begin
                    state_n      = S_IDLE;
                    flush_done_n = 1'b1;
                end else if (valid[fidx] && dirty[fidx]) begin
                    state_n     = S_FLUSH_WB;
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b1;
                    mem_addr_n  = {tag_mem[fidx], fidx};
                    mem_wdata_n = data_mem[fidx];
                end else begin
                    line_we = 1'b1;
                    cnt_n   = cnt + 1'b1;
                end
            end
            S_FLUSH_WB: begin
                line_idx = fidx;
                if (acked) begin
                    mem_req_n = 1'b0;
                    mem_we_n  = 1'b0;
                    line_we   = 1'b1;
                    cnt_n     = cnt + 1'b1;
                    state_n   = S_FLUSH_CHECK;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            valid      <= '0;
            dirty      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            flush_done <= 1'b0;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            flush_done <= flush_done_n;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (line_we) begin
                valid[line_idx] <= line_valid_n;
                dirty[line_idx] <= line_dirty_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_mem[cur_idx] <= data_wval;
        if (tag_we)  tag_mem[cur_idx]  <= cur_tag;
    end
endmodule

// File: doc/dm_cache_wb.md
Name: dm_cache_wb

Overview:
Parametrised direct-mapped write-back cache controller with write-allocate. It replaces the fixed 5-bit/8-line cache built from separate tag, valid and data RAMs with one block that owns its own storage. It adds a dirty bit per line, a valid/ready request handshake, a multi-cycle memory-side handshake and a full-cache flush. It sits between the processor load/store path and main memory.

Parameters:
ADDR_BITS, 5, word address width
INDEX_BITS, 3, index width; lines = 2**INDEX_BITS; tag = ADDR_BITS-INDEX_BITS (must be >=1)
DATA_WIDTH, 32, word width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  CPU request present
req_ready  out  1  high when state==IDLE and flush==0
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_BITS  word address
req_wdata  in  DATA_WIDTH  write data
resp_valid  out  1  one-cycle completion pulse (reads and writes)
resp_rdata  out  DATA_WIDTH  read data, valid with resp_valid
mem_req  out  1  memory request, held until acked
mem_we  out  1  memory write
mem_addr  out  ADDR_BITS  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, single-cycle
flush  in  1  start flush (sampled in IDLE)
flush_done  out  1  one-cycle pulse at flush end

Behaviour:
- Reset (async): state=IDLE; all valid and dirty bits=0; resp_valid, mem_req, mem_we, flush_done=0; resp_rdata, mem_addr, mem_wdata=0. Tag/data arrays are not reset. Reset mid-transaction abandons the transaction and drops mem_req immediately.
- All outputs except req_ready are registered.
- Request accept: req_valid && req_ready at a clock edge latches we/addr/wdata; next state=COMPARE.
- COMPARE: hit = valid[idx] && tag[idx]==latched tag.
  - Read hit: resp_rdata=data[idx], resp_valid=1, go to IDLE.
  - Write hit: data[idx]=wdata, dirty[idx]=1, resp_valid=1, go to IDLE.
  - Miss with valid && dirty: go to WRITEBACK.
  - Any other miss: go to REFILL.
- Hit latency: request accepted at edge E0; resp_valid is high in the cycle after E1. A new request may be accepted while resp_valid is high.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={tag[idx],idx}, mem_wdata=data[idx].
  - Hold all of these until the edge where mem_ack=1, then drop mem_req and go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr=latched addr.
  - At the edge with mem_ack=1: data[idx]=mem_rdata, tag[idx]=latched tag, valid=1, dirty=0; drop mem_req; go to COMPARE, which then hits.
  - A write miss is therefore allocated first, then written, leaving the line dirty.
- mem_ack outside an active mem_req is ignored.
- Flush: flush=1 in IDLE has priority over req_valid (req_ready=0). An index counter starts at 0.
  - FLUSH_CHECK: if valid && dirty go to FLUSH_WB; else clear valid/dirty of the line and advance the counter.
  - FLUSH_WB: same handshake as WRITEBACK; on ack clear valid/dirty, advance, return to FLUSH_CHECK.
  - After the last line (2**INDEX_BITS-1): go to IDLE, pulse flush_done for one cycle.
  - flush while not in IDLE is ignored.
- req_addr/req_wdata changes while not in IDLE have no effect (latched copy used).
- Index counter width = INDEX_BITS+1 so the terminal count is detected without wrap.

Test Plan:
- Reset, then read addr 1 with memory returning 0xAAAA after 3-cycle ack → one memory read of addr 1; resp_rdata=0xAAAA; then a second read of addr 1 → hit, resp_valid 2 cycles after accept, no mem_req.
- Write addr 2 data 6 (miss, refill returns 0) → one memory read, resp_valid, no memory write; read addr 2 → hit, 6.
- Dirty eviction: after the previous test, read addr 10 (same index 2, tag 1) → mem write addr 2 data 6, then mem read addr 10, in that order; then read addr 2 → miss with no writeback (line clean).
- Memory stall: hold mem_ack=0 for 20 cycles during REFILL → mem_req/mem_addr stable for all 20 cycles, req_ready=0, no resp_valid.
- Flush with lines 1 (dirty, 0x11) and 5 (dirty, 0x55) → exactly two memory writes (addr 1, then addr 5), flush_done one pulse; next read addr 1 misses.
- Assert reset during WRITEBACK → mem_req low immediately; the following read of any address misses.
